// File: rtl/rf_commit_tracer.sv
`default_nettype none
// ============================================================================
// Module      : rf_commit_tracer
// Description : Register-file commit trace buffer. Every architectural
//               register write (enable high, address non-zero) becomes a
//               sequence-tagged record in a first-word-fall-through FIFO,
//               presented on a valid/ready stream. Events arriving while the
//               FIFO is full are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_commit_tracer #(
    parameter int BUF_SIZE       = 32,
    parameter int BUF_ADDR_WIDTH = 5,
    parameter int SEQ_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rf_wen,
    input  logic [4:0]                rf_wa,
    input  logic [31:0]               rf_wd,
    output logic                      tr_valid,
    input  logic                      tr_ready,
    output logic [SEQ_WIDTH-1:0]      tr_seq,
    output logic [4:0]                tr_addr,
    output logic [31:0]               tr_data,
    output logic [BUF_ADDR_WIDTH:0]   level,
    output logic                      overflow,
    output logic [15:0]               drop_cnt,
    input  logic                      clr_overflow
);

    localparam int                    c_REC_W      = SEQ_WIDTH + 5 + 32;
    localparam logic [BUF_ADDR_WIDTH:0] c_FULL_LEVEL = (BUF_ADDR_WIDTH+1)'(BUF_SIZE);
    localparam logic [15:0]           c_DROP_MAX   = 16'hFFFF;

    // Record storage; contents are deliberately not reset.
    logic [c_REC_W-1:0]        mem_q [BUF_SIZE];

    logic [BUF_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_ADDR_WIDTH:0]   level_q,  level_d;
    logic [SEQ_WIDTH-1:0]      seq_cnt_q, seq_cnt_d;
    logic                      overflow_q, overflow_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    logic                      w_ev;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic [c_REC_W-1:0]        w_head;

    // Event classification and next-state computation for all counters.
    always_comb begin
        w_ev       = rf_wen & (rf_wa != 5'd0);
        w_full     = (level_q == c_FULL_LEVEL);
        // Full/empty are taken from level: pointers alone are ambiguous.
        w_pop      = (level_q != '0) & tr_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push     = w_ev & (~w_full | w_pop);
        w_drop     = w_ev & w_full & ~w_pop;

        wr_ptr_d   = w_push ? wr_ptr_q + BUF_ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + BUF_ADDR_WIDTH'(1) : rd_ptr_q;

        level_d    = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + (BUF_ADDR_WIDTH+1)'(1);
        end else if (w_pop && !w_push) begin
            level_d = level_q - (BUF_ADDR_WIDTH+1)'(1);
        end

        // Dropped events still consume a number so the reader sees a gap.
        seq_cnt_d  = w_ev ? seq_cnt_q + SEQ_WIDTH'(1) : seq_cnt_q;

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (w_drop) begin
            // A drop coinciding with a clear restarts the count at one.
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != c_DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_cnt_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_cnt_q  <= seq_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record write; the stored sequence number is the pre-increment value.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {seq_cnt_q, rf_wa, rf_wd};
        end
    end

    // Fall-through head; fields are forced to zero whenever nothing is held.
    assign w_head   = mem_q[rd_ptr_q];
    assign tr_valid = (level_q != '0);
    assign tr_seq   = tr_valid ? w_head[c_REC_W-1 -: SEQ_WIDTH] : '0;
    assign tr_addr  = tr_valid ? w_head[36:32] : 5'd0;
    assign tr_data  = tr_valid ? w_head[31:0]  : 32'd0;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_commit_tracer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_commit_tracer
// Description : Self-checking bench for rf_commit_tracer. A queue-based
//               reference model tracks the expected FIFO contents, sequence
//               counter and drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_commit_tracer;

    logic        clk;
    logic        rst;
    logic        rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        tr_valid;
    logic        tr_ready;
    logic [15:0] tr_seq;
    logic [4:0]  tr_addr;
    logic [31:0] tr_data;
    logic [5:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_overflow;

    rf_commit_tracer #(
        .BUF_SIZE       (32),
        .BUF_ADDR_WIDTH (5),
        .SEQ_WIDTH      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rf_wen       (rf_wen),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .tr_valid     (tr_valid),
        .tr_ready     (tr_ready),
        .tr_seq       (tr_seq),
        .tr_addr      (tr_addr),
        .tr_data      (tr_data),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: records are {seq[16], addr[5], data[32]}.
    logic [52:0] mq[$];
    int          m_seq;
    logic        m_ovf;
    int          m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq  = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // Applies one clock of inputs to the model, using the model's own state.
    task automatic model_step(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rdy, input logic clr);
        bit ev, pop, full;
        ev   = wen && (wa != 0);
        full = (mq.size() == 32);
        pop  = (mq.size() != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (!full || pop) begin
                mq.push_back({m_seq[15:0], wa, wd});
            end else begin
                m_ovf = 1'b1;
                if (clr) m_drop = 1;
                else if (m_drop < 65535) m_drop = m_drop + 1;
            end
            m_seq = (m_seq + 1) % 65536;
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (ev && !(!full || pop) == 1'b0 && clr) begin
            // accepted event with clear: clear still applies
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [52:0] rec;
        rec = (mq.size() != 0) ? mq[0] : 53'd0;
        chk({tag, "_valid"}, 64'(tr_valid), 64'(mq.size() != 0));
        chk({tag, "_level"}, 64'(level),    64'(mq.size()));
        chk({tag, "_ovf"},   64'(overflow), 64'(m_ovf));
        chk({tag, "_drop"},  64'(drop_cnt), 64'(m_drop));
        chk({tag, "_seq"},   64'(tr_seq),   64'(rec[52:37]));
        chk({tag, "_addr"},  64'(tr_addr),  64'(rec[36:32]));
        chk({tag, "_data"},  64'(tr_data),  64'(rec[31:0]));
    endtask

    // Drive one cycle of inputs (called 1 time unit after a rising edge).
    task automatic step(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rdy, input logic clr, input string tag);
        rf_wen = wen; rf_wa = wa; rf_wd = wd; tr_ready = rdy; clr_overflow = clr;
        @(posedge clk);
        model_step(wen, wa, wd, rdy, clr);
        #1;
        rf_wen = 1'b0; tr_ready = 1'b0; clr_overflow = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        rst = 1'b1; rf_wen = 1'b0; rf_wa = '0; rf_wd = '0;
        tr_ready = 1'b0; clr_overflow = 1'b0;
        model_reset();

        // Reset then single write and pop.
        do_reset();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, "t1_wr");
        chk("t1_seq_abs",  64'(tr_seq),  64'd0);
        chk("t1_addr_abs", 64'(tr_addr), 64'd5);
        chk("t1_data_abs", 64'(tr_data), 64'hDEADBEEF);
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "t1_pop");
        chk("t1_empty_abs", 64'(tr_valid), 64'd0);

        // r0 writes are invisible and do not consume sequence numbers.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 32'h1234 + i, 1'b0, 1'b0, "t2_r0");
        step(1'b1, 5'd1, 32'hCAFE, 1'b0, 1'b0, "t2_r1");
        chk("t2_seq_abs", 64'(tr_seq), 64'd0);

        // Fill, overflow by two, drain, clear.
        do_reset();
        for (int i = 0; i < 34; i++) step(1'b1, 5'((i % 31) + 1), 32'(i), 1'b0, 1'b0, "t3_fill");
        chk("t3_level_abs", 64'(level),    64'd32);
        chk("t3_ovf_abs",   64'(overflow), 64'd1);
        chk("t3_drop_abs",  64'(drop_cnt), 64'd2);
        for (int i = 0; i < 32; i++) begin
            chk("t3_drain_seq_abs", 64'(tr_seq), 64'(i));
            step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "t3_drain");
        end
        step(1'b1, 5'd7, 32'h77, 1'b0, 1'b0, "t3_next");
        chk("t3_next_seq_abs", 64'(tr_seq), 64'd34);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, "t3_clr");
        chk("t3_clr_drop_abs", 64'(drop_cnt), 64'd0);

        // Full with simultaneous pop and write every cycle.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 5'd3, 32'(i), 1'b0, 1'b0, "t4_fill");
        for (int i = 0; i < 40; i++) begin
            chk("t4_consec_seq_abs", 64'(tr_seq), 64'(i));
            step(1'b1, 5'd4, 32'(100 + i), 1'b1, 1'b0, "t4_stream");
        end
        chk("t4_drop_abs", 64'(drop_cnt), 64'd0);

        // Clear colliding with a drop at full.
        step(1'b1, 5'd9, 32'h99, 1'b0, 1'b0, "t5_pre");
        step(1'b1, 5'd9, 32'h9A, 1'b0, 1'b0, "t5_pre2");
        step(1'b1, 5'd9, 32'h9B, 1'b0, 1'b1, "t5_collide");
        chk("t5_ovf_abs",  64'(overflow), 64'd1);
        chk("t5_drop_abs", 64'(drop_cnt), 64'd1);

        // Asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 5'd2, 32'(i), 1'b0, 1'b0, "t6_fill");
        #4;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 5'd6, 32'h66, 1'b0, 1'b0, "t6_after");
        chk("t6_seq_abs", 64'(tr_seq), 64'd0);

        // Randomized traffic in phases of varying reader back-pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 80; i++) begin
                logic       wen, rdy, clr;
                logic [4:0] wa;
                wen = ($urandom_range(99) < 80);
                wa  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
                rdy = ($urandom_range(99) < rdy_pct);
                clr = ($urandom_range(49) == 0);
                step(wen, wa, $urandom, rdy, clr, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
